// File: rtl/if_queue_pkg.sv
// rtl/if_queue_pkg.sv - shared types and sizes for the instruction fetch queue
//
// Holds the default widths/depth and the entry record carried from the
// SRAM response stage through the queue to decode.
package if_queue_pkg;

    localparam int IF_ADDR_WIDTH = 32;
    localparam int IF_INST_WIDTH = 32;
    localparam int IF_DEPTH      = 4;
    localparam int PTR_W         = $clog2(IF_DEPTH);

    // One decoded-side queue entry: fetch PC, fetched word and prediction.
    typedef struct packed {
        logic [IF_ADDR_WIDTH-1:0] pc;
        logic [IF_INST_WIDTH-1:0] inst;
        logic                     branch;
        logic [IF_ADDR_WIDTH-1:0] branch_addr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with synchronous clear
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and data (ignored when full without a pop)
//   pop           read request (ignored when empty)
//   clear         synchronous discard of all contents
//   dout          head entry (valid when count != 0)
//   count         occupancy, 0..DEPTH
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  T                       din,
    output T                       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL  = (PTR_W+1)'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO may still accept a write when the head leaves the same cycle.
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_inst_queue.sv
// rtl/if_inst_queue.sv - instruction fetch queue between PC generator and decode
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   fetch_valid, fetch_pc             new PC request from fetch
//   fetch_branch, fetch_branch_addr   prediction attached to that PC
//   fetch_stall                       fetch must hold its PC (not accepted)
//   flush                             drop all queued and in-flight entries
//   imem_en, imem_addr, imem_rdata    synchronous instruction SRAM port
//   id_valid, id_ready                decode handshake on the queue head
//   id_pc, id_inst, id_branch,
//   id_branch_addr                    head entry fields (zero when empty)
module if_inst_queue
    import if_queue_pkg::*;
#(
    parameter int DEPTH      = IF_DEPTH,
    parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int INST_WIDTH = IF_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  fetch_branch,
    input  logic [ADDR_WIDTH-1:0] fetch_branch_addr,
    output logic                  fetch_stall,
    input  logic                  flush,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic                  id_branch,
    output logic [ADDR_WIDTH-1:0] id_branch_addr
);

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    OCC_LIMIT = (CW+1)'(DEPTH);

    logic                  inflight_v;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight_branch;
    logic [ADDR_WIDTH-1:0] inflight_branch_addr;

    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic                  accept;
    fetch_entry_t          enq_entry;
    fetch_entry_t          head;

    // Credit check uses registered state only: the in-flight word already
    // owns a slot, and a same-cycle pop is deliberately not credited so that
    // id_ready never reaches fetch_stall combinationally.
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight_v};
    assign fetch_stall = (occupancy >= OCC_LIMIT);

    assign accept    = fetch_valid && !fetch_stall && !flush;
    assign imem_en   = accept;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_v           <= 1'b0;
            inflight_pc          <= '0;
            inflight_branch      <= 1'b0;
            inflight_branch_addr <= '0;
        end else begin
            // accept is already low during flush, which kills the in-flight slot
            inflight_v <= accept;
            if (accept) begin
                inflight_pc          <= fetch_pc;
                inflight_branch      <= fetch_branch;
                inflight_branch_addr <= fetch_branch_addr;
            end
        end
    end

    always_comb begin
        enq_entry             = '0;
        enq_entry.pc          = inflight_pc;
        enq_entry.inst        = imem_rdata;
        enq_entry.branch      = inflight_branch;
        enq_entry.branch_addr = inflight_branch_addr;
    end

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_v && !flush),
        .pop   (id_valid && id_ready && !flush),
        .clear (flush),
        .din   (enq_entry),
        .dout  (head),
        .count (count)
    );

    // Head fields are forced to zero when empty so stale storage never leaks.
    assign id_valid       = (count != '0);
    assign id_pc          = id_valid ? head.pc          : '0;
    assign id_inst        = id_valid ? head.inst        : '0;
    assign id_branch      = id_valid ? head.branch      : 1'b0;
    assign id_branch_addr = id_valid ? head.branch_addr : '0;

endmodule

// File: tb/tb_if_inst_queue.sv
// tb/tb_if_inst_queue.sv - directed self-checking bench for if_inst_queue
module tb_if_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_branch;
    logic [31:0] fetch_branch_addr;
    logic        fetch_stall;
    logic        flush;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_branch;
    logic [31:0] id_branch_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_inst_queue dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_branch      (fetch_branch),
        .fetch_branch_addr (fetch_branch_addr),
        .fetch_stall       (fetch_stall),
        .flush             (flush),
        .imem_en           (imem_en),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .id_valid          (id_valid),
        .id_ready          (id_ready),
        .id_pc             (id_pc),
        .id_inst           (id_inst),
        .id_branch         (id_branch),
        .id_branch_addr    (id_branch_addr)
    );

    // Synchronous SRAM model: word = address ^ 0xFFFF, one cycle after enable.
    logic [31:0] sram_q = 32'h0;
    always_ff @(posedge clk) begin
        if (imem_en) sram_q <= imem_addr ^ 32'h0000_FFFF;
    end
    assign imem_rdata = sram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_branch = 1'b0;
        fetch_branch_addr = '0; flush = 1'b0; id_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #2;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL reset_fetch_stall got %b exp 0", fetch_stall); end
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL reset_imem_en got %b exp 0", imem_en); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
        total++; if (id_inst !== 32'h0) begin bad++; $display("FAIL reset_id_inst got %h exp 0", id_inst); end
        total++; if (id_branch !== 1'b0) begin bad++; $display("FAIL reset_id_branch got %b exp 0", id_branch); end
        total++; if (id_branch_addr !== 32'h0) begin bad++; $display("FAIL reset_id_branch_addr got %h exp 0", id_branch_addr); end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        for (int c = 0; c < 7; c++) begin
            fetch_valid = (c < 3);
            fetch_pc    = 32'h1c00_0000 + 32'(4 * c);
            id_ready    = 1'b1;
            #2;
            exp_pc = 32'h1c00_0000 + 32'(4 * (c - 2));
            total++; if (id_valid !== (c >= 2 && c <= 4)) begin bad++; $display("FAIL stream_id_valid c=%0d got %b", c, id_valid); end
            total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL stream_fetch_stall c=%0d got %b exp 0", c, fetch_stall); end
            total++; if (imem_en !== (c < 3)) begin bad++; $display("FAIL stream_imem_en c=%0d got %b", c, imem_en); end
            if (c >= 2 && c <= 4) begin
                total++; if (id_pc !== exp_pc) begin bad++; $display("FAIL stream_id_pc c=%0d got %h exp %h", c, id_pc, exp_pc); end
                total++; if (id_inst !== (exp_pc ^ 32'h0000_FFFF)) begin bad++; $display("FAIL stream_id_inst c=%0d got %h exp %h", c, id_inst, exp_pc ^ 32'h0000_FFFF); end
            end
            tick();
        end
        fetch_valid = 1'b0;
    endtask

    task automatic test_fill();
        int n_acc = 0;
        for (int c = 0; c < 7; c++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 32'h1c00_0400 + 32'(4 * ((c < 4) ? c : 4));
            id_ready    = 1'b0;
            #2;
            if (imem_en === 1'b1) n_acc++;
            total++; if (fetch_stall !== (c >= 4)) begin bad++; $display("FAIL fill_fetch_stall c=%0d got %b", c, fetch_stall); end
            total++; if (imem_en !== (c < 4)) begin bad++; $display("FAIL fill_imem_en c=%0d got %b", c, imem_en); end
            if (c >= 2) begin
                total++; if (id_valid !== 1'b1 || id_pc !== 32'h1c00_0400) begin bad++; $display("FAIL fill_head c=%0d got %b/%h exp 1/1c000400", c, id_valid, id_pc); end
            end
            tick();
        end
        total++; if (n_acc != 4) begin bad++; $display("FAIL fill_accepts got %0d exp 4", n_acc); end
    endtask

    task automatic test_drain();
        int n_acc = 0;
        fetch_valid = 1'b1; fetch_pc = 32'h1c00_0410; id_ready = 1'b1;
        #2;
        total++; if (fetch_stall !== 1'b1 || imem_en !== 1'b0) begin bad++; $display("FAIL drain_full got stall=%b en=%b exp 1/0", fetch_stall, imem_en); end
        total++; if (id_pc !== 32'h1c00_0400) begin bad++; $display("FAIL drain_head0 got %h exp 1c000400", id_pc); end
        tick();
        id_ready = 1'b0;
        #2;
        if (imem_en === 1'b1) n_acc++;
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL drain_release got %b exp 0", fetch_stall); end
        total++; if (id_pc !== 32'h1c00_0404) begin bad++; $display("FAIL drain_head1 got %h exp 1c000404", id_pc); end
        tick();
        fetch_pc = 32'h1c00_0414;
        for (int c = 0; c < 2; c++) begin
            #2;
            if (imem_en === 1'b1) n_acc++;
            total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL drain_restall c=%0d got %b exp 1", c, fetch_stall); end
            tick();
        end
        total++; if (n_acc != 1) begin bad++; $display("FAIL drain_accepts got %0d exp 1", n_acc); end
        fetch_valid = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1; fetch_valid = 1'b0; id_ready = 1'b0;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 32'h1c00_0800 + 32'(4 * k);
            #2;
            total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL flush_setup k=%0d got %b exp 1", k, imem_en); end
            tick();
        end
        // three queued plus one in flight
        flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h1c00_0100;
        #2;
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL flush_imem_en got %b exp 0", imem_en); end
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h1c00_0800) begin bad++; $display("FAIL flush_prehead got %b/%h exp 1/1c000800", id_valid, id_pc); end
        tick();
        flush = 1'b0;
        #2;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_id_valid got %b exp 0", id_valid); end
        total++; if (fetch_stall !== 1'b0 || imem_en !== 1'b1) begin bad++; $display("FAIL flush_reaccept got stall=%b en=%b exp 0/1", fetch_stall, imem_en); end
        tick();
        fetch_valid = 1'b0;
        #2;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_gap got %b exp 0", id_valid); end
        tick();
        #2;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h1c00_0100) begin bad++; $display("FAIL flush_newpc got %b/%h exp 1/1c000100", id_valid, id_pc); end
        total++; if (id_inst !== 32'h1c00_FEFF) begin bad++; $display("FAIL flush_newinst got %h exp 1c00feff", id_inst); end
        id_ready = 1'b1;
        tick();
        #2;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_single got %b exp 0", id_valid); end
    endtask

    task automatic test_branch();
        flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h1c00_0010;
        fetch_branch = 1'b1; fetch_branch_addr = 32'h1c00_0200; id_ready = 1'b1;
        #2;
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL branch_flush_en got %b exp 0", imem_en); end
        tick();
        flush = 1'b0;
        #2;
        total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL branch_accept got %b exp 1", imem_en); end
        tick();
        fetch_pc = 32'h1c00_0014; fetch_branch = 1'b0; fetch_branch_addr = 32'h0;
        tick();
        fetch_valid = 1'b0;
        #2;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h1c00_0010 || id_inst !== 32'h1c00_FFEF) begin bad++; $display("FAIL branch_head0 got %b/%h/%h exp 1/1c000010/1c00ffef", id_valid, id_pc, id_inst); end
        total++; if (id_branch !== 1'b1 || id_branch_addr !== 32'h1c00_0200) begin bad++; $display("FAIL branch_fields0 got %b/%h exp 1/1c000200", id_branch, id_branch_addr); end
        tick();
        #2;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h1c00_0014 || id_inst !== 32'h1c00_FFEB) begin bad++; $display("FAIL branch_head1 got %b/%h/%h exp 1/1c000014/1c00ffeb", id_valid, id_pc, id_inst); end
        total++; if (id_branch !== 1'b0 || id_branch_addr !== 32'h0) begin bad++; $display("FAIL branch_fields1 got %b/%h exp 0/0", id_branch, id_branch_addr); end
        tick();
        #2;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL branch_empty got %b exp 0", id_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] exp_pc;
        int sent   = 0;
        int popped = 0;
        for (int cyc = 0; cyc < 400 && popped < 24; cyc++) begin
            fetch_valid = (sent < 24);
            fetch_pc    = 32'h1c00_1000 + 32'(4 * sent);
            id_ready    = 1'($urandom_range(0, 1));
            #2;
            total++; if (sent - popped > 4) begin bad++; $display("FAIL wrap_occupancy cyc=%0d got %0d exp <=4", cyc, sent - popped); end
            total++; if (imem_en !== (fetch_valid && !fetch_stall)) begin bad++; $display("FAIL wrap_imem_en cyc=%0d got %b", cyc, imem_en); end
            if (id_valid === 1'b1 && id_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL wrap_spurious cyc=%0d got %h exp none", cyc, id_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    total++; if (id_pc !== exp_pc) begin bad++; $display("FAIL wrap_id_pc n=%0d got %h exp %h", popped, id_pc, exp_pc); end
                    total++; if (id_inst !== (exp_pc ^ 32'h0000_FFFF)) begin bad++; $display("FAIL wrap_id_inst n=%0d got %h exp %h", popped, id_inst, exp_pc ^ 32'h0000_FFFF); end
                end
                popped++;
            end
            if (fetch_valid && fetch_stall === 1'b0) begin
                exp_q.push_back(fetch_pc);
                sent++;
            end
            tick();
        end
        fetch_valid = 1'b0;
        total++; if (popped != 24) begin bad++; $display("FAIL wrap_drained got %0d exp 24", popped); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_drain();
        test_flush();
        test_branch();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
